// File: rtl/md5_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md5_block_sequencer_pkg
// Purpose  : Shared constants, state type and step helper functions for the
//            iterative MD5 block sequencer (K/S tables, IV, F and g rules).
// Revision : 1.0 - initial release
// ============================================================================
package md5_block_sequencer_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hEFCDAB89;
  localparam logic [31:0] IV_C = 32'h98BADCFE;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [31:0] IV [4] = '{IV_A, IV_B, IV_C, IV_D};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Sine-derived additive constants, one per step.
  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amount S[i]: depends only on the round and i mod 4.
  function automatic logic [4:0] s_shift(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'b0000: s = 5'd7;   4'b0001: s = 5'd12; 4'b0010: s = 5'd17; 4'b0011: s = 5'd22;
      4'b0100: s = 5'd5;   4'b0101: s = 5'd9;  4'b0110: s = 5'd14; 4'b0111: s = 5'd20;
      4'b1000: s = 5'd4;   4'b1001: s = 5'd11; 4'b1010: s = 5'd16; 4'b1011: s = 5'd23;
      4'b1100: s = 5'd6;   4'b1101: s = 5'd10; 4'b1110: s = 5'd15; default: s = 5'd21;
    endcase
    return s;
  endfunction

  // Round boolean function selected by the round number (i / 16).
  function automatic logic [31:0] f_round(input logic [1:0] rnd, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [31:0] f;
    case (rnd)
      2'd0:    f = (b & c) | (~b & d);
      2'd1:    f = (d & b) | (~d & c);
      2'd2:    f = b ^ c ^ d;
      default: f = c ^ (b | ~d);
    endcase
    return f;
  endfunction

  // Message word index; multiples of 16 vanish mod 16, so only i[3:0] matters.
  function automatic logic [3:0] g_index(input logic [5:0] i);
    logic [3:0] lo;
    logic [3:0] g;
    lo = i[3:0];
    case (i[5:4])
      2'd0:    g = lo;
      2'd1:    g = lo * 4'd5 + 4'd1;
      2'd2:    g = lo * 4'd3 + 4'd5;
      default: g = lo * 4'd7;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/md5_block_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : md5_block_sequencer_if
// Purpose  : Word input stream and digest output stream of the MD5 sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface md5_block_sequencer_if;
  logic [31:0]  in_data_i;
  logic         in_valid_i;
  logic         in_last_i;
  logic         in_ready_o;
  logic [127:0] digest_o;
  logic         digest_valid_o;
  logic         digest_ready_i;
  logic         busy_o;

  modport master (
    output in_data_i, in_valid_i, in_last_i, digest_ready_i,
    input  in_ready_o, digest_o, digest_valid_o, busy_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, digest_ready_i,
    output in_ready_o, digest_o, digest_valid_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/md5_block_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module   : md5_step
// Purpose  : One combinational MD5 step; the caller supplies M[g], K[i], S[i]
//            and the round select.
// Revision : 1.0 - initial release
// ============================================================================
module md5_step
  import md5_block_sequencer_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [31:0] k,
  input  logic [4:0]  s,
  input  logic [1:0]  rnd,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next
);
  logic [31:0] sum;
  logic [63:0] rot_dbl;

  // Step update: rotate the sum left by s (upper half of the doubled word) and rotate registers.
  always_comb begin
    sum     = a + f_round(rnd, b, c, d) + k + m;
    rot_dbl = {sum, sum} << s;
    a_next  = d;
    b_next  = b + rot_dbl[63:32];
    c_next  = b;
    d_next  = c;
  end
endmodule
`default_nettype wire

// File: rtl/md5_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md5_block_sequencer
// Purpose  : Iterative MD5 compression controller. Loads 16-word blocks,
//            runs 64 steps over UNROLL chained step units, chains H across
//            blocks and presents the final digest on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module md5_block_sequencer
  import md5_block_sequencer_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  md5_block_sequencer_if.slave bus
);
  localparam logic [5:0] STEP_INC  = 6'(UNROLL);
  localparam logic [5:0] STEP_LAST = 6'(64 - UNROLL);

  state_t       state;
  state_t       state_next;
  logic [31:0]  msg [16];
  logic [3:0]   word_idx;
  logic [5:0]   step;
  logic         last;
  logic [31:0]  h [4];
  logic [31:0]  sum_h [4];
  logic [31:0]  work_a, work_b, work_c, work_d;
  logic [127:0] digest;
  logic         digest_valid;
  logic         ready;
  logic         xfer;
  logic         accept;

  logic [31:0]  ch_a [UNROLL+1];
  logic [31:0]  ch_b [UNROLL+1];
  logic [31:0]  ch_c [UNROLL+1];
  logic [31:0]  ch_d [UNROLL+1];

  // Words are only taken while idle or loading; reset blocks any transfer.
  assign ready  = ((state == ST_IDLE) || (state == ST_LOAD)) && !rst_i;
  assign xfer   = bus.in_valid_i && ready;
  assign accept = digest_valid && bus.digest_ready_i;

  assign bus.in_ready_o     = ready;
  assign bus.busy_o         = (state != ST_IDLE);
  assign bus.digest_o       = digest;
  assign bus.digest_valid_o = digest_valid;

  assign ch_a[0] = work_a;
  assign ch_b[0] = work_b;
  assign ch_c[0] = work_c;
  assign ch_d[0] = work_d;

  // Step chain: unit u evaluates step (step + u); step is a multiple of UNROLL so no wrap occurs.
  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    logic [5:0] idx;
    assign idx = step + 6'(u);
    md5_step u_step (
      .a      (ch_a[u]),
      .b      (ch_b[u]),
      .c      (ch_c[u]),
      .d      (ch_d[u]),
      .m      (msg[g_index(idx)]),
      .k      (K_TABLE[idx]),
      .s      (s_shift(idx)),
      .rnd    (idx[5:4]),
      .a_next (ch_a[u+1]),
      .b_next (ch_b[u+1]),
      .c_next (ch_c[u+1]),
      .d_next (ch_d[u+1])
    );
  end

  // Chaining add of the working registers into H.
  always_comb begin
    sum_h[0] = h[0] + work_a;
    sum_h[1] = h[1] + work_b;
    sum_h[2] = h[2] + work_c;
    sum_h[3] = h[3] + work_d;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (xfer) state_next = ST_LOAD;
      ST_LOAD: if (xfer && (word_idx == 4'd15)) state_next = ST_RUN;
      ST_RUN:  if (step == STEP_LAST) state_next = ST_ADD;
      ST_ADD:  state_next = last ? ST_DONE : ST_IDLE;
      ST_DONE: if (accept) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Message buffer write; contents are don't-care until all 16 words arrive.
  always_ff @(posedge clk_i) begin
    if (xfer) msg[word_idx] <= bus.in_data_i;
  end

  // Datapath: word index, working registers, chaining value and digest register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int j = 0; j < 4; j++) h[j] <= IV[j];
      word_idx     <= 4'd0;
      step         <= 6'd0;
      last         <= 1'b0;
      work_a       <= 32'd0;
      work_b       <= 32'd0;
      work_c       <= 32'd0;
      work_d       <= 32'd0;
      digest       <= 128'd0;
      digest_valid <= 1'b0;
    end else begin
      if (xfer) begin
        word_idx <= word_idx + 4'd1;
        if (word_idx == 4'd15) begin
          last   <= bus.in_last_i;
          work_a <= h[0];
          work_b <= h[1];
          work_c <= h[2];
          work_d <= h[3];
          step   <= 6'd0;
        end
      end
      if (state == ST_RUN) begin
        work_a <= ch_a[UNROLL];
        work_b <= ch_b[UNROLL];
        work_c <= ch_c[UNROLL];
        work_d <= ch_d[UNROLL];
        step   <= step + STEP_INC;
      end
      if (state == ST_ADD) begin
        for (int j = 0; j < 4; j++) h[j] <= sum_h[j];
        word_idx <= 4'd0;
        if (last) begin
          digest       <= {bswap32(sum_h[0]), bswap32(sum_h[1]),
                           bswap32(sum_h[2]), bswap32(sum_h[3])};
          digest_valid <= 1'b1;
        end
      end
      if (accept) begin
        digest_valid <= 1'b0;
        for (int j = 0; j < 4; j++) h[j] <= IV[j];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_md5_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md5_block_sequencer
// Purpose  : Self-checking bench for three sequencer instances (UNROLL 1/2/4)
//            against a block-level MD5 reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md5_block_sequencer;
  localparam logic [127:0] IV_P    = 128'h67452301_EFCDAB89_98BADCFE_10325476;
  localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
  localparam logic [127:0] D_NUM   = 128'h57edf4a22be3c955ac49da2e2107b67a;

  localparam logic [31:0] KT [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int SH [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  logic         clk;
  logic         rst;
  logic [31:0]  in_data [3];
  logic         in_valid [3];
  logic         in_last [3];
  logic         dig_ready [3];
  logic [2:0]   rdy;
  logic [2:0]   dvalid;
  logic [2:0]   busy;
  logic [127:0] dig [3];

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  // Reference model state per instance: phase 0 accepting, 1 computing, 2 digest pending.
  int           m_phase [3];
  int           m_idx [3];
  int           m_left [3];
  bit           m_last [3];
  logic [511:0] m_msg [3];
  logic [127:0] m_h [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    md5_block_sequencer_if bus ();
    assign bus.in_data_i      = in_data[k];
    assign bus.in_valid_i     = in_valid[k];
    assign bus.in_last_i      = in_last[k];
    assign bus.digest_ready_i = dig_ready[k];
    assign rdy[k]             = bus.in_ready_o;
    assign dvalid[k]          = bus.digest_valid_o;
    assign busy[k]            = bus.busy_o;
    assign dig[k]             = bus.digest_o;
    md5_block_sequencer #(.UNROLL(1 << k)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bsw(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [127:0] digest_of(input logic [127:0] h);
    return {bsw(h[127:96]), bsw(h[95:64]), bsw(h[63:32]), bsw(h[31:0])};
  endfunction

  // Whole-block MD5 compression, straight from the step rules.
  function automatic logic [127:0] md5_compress(input logic [127:0] h, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, t, x;
    int g, s;
    a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s = SH[i / 16][i % 4];
      t = a + f + KT[i] + blk[32 * g +: 32];
      x = (t << s) | (t >> (32 - s));
      a = d; d = c; c = b; b = b + x;
    end
    return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
  endfunction

  function automatic logic [511:0] blk_empty();
    logic [511:0] b;
    b = '0;
    b[31:0] = 32'h00000080;
    return b;
  endfunction

  function automatic logic [511:0] blk_abc();
    logic [511:0] b;
    b = '0;
    b[31:0]        = 32'h80636261;
    b[32 * 14 +: 32] = 32'h00000018;
    return b;
  endfunction

  // Byte n of the padded 80-character "1234567890" x 8 message (640 bits).
  function automatic logic [7:0] num_byte(input int n);
    if (n < 80)  return (n % 10 == 9) ? 8'h30 : 8'(49 + n % 10);
    if (n == 80) return 8'h80;
    if (n == 120) return 8'h80;
    if (n == 121) return 8'h02;
    return 8'h00;
  endfunction

  function automatic logic [511:0] blk_num(input int bi);
    logic [511:0] b;
    for (int j = 0; j < 64; j++) b[8 * j +: 8] = num_byte(bi * 64 + j);
    return b;
  endfunction

  // Reference model, advanced on every rising edge from the stimulus alone.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_phase[k] = 0; m_idx[k] = 0; m_left[k] = 0; m_h[k] = IV_P;
      end else begin
        case (m_phase[k])
          0: if (in_valid[k]) begin
            m_msg[k][32 * m_idx[k] +: 32] = in_data[k];
            if (m_idx[k] == 15) begin
              m_last[k]  = in_last[k];
              m_h[k]     = md5_compress(m_h[k], m_msg[k]);
              m_phase[k] = 1;
              m_left[k]  = 64 / (1 << k) + 1;
              m_idx[k]   = 0;
            end else m_idx[k]++;
          end
          1: begin
            m_left[k]--;
            if (m_left[k] == 0) m_phase[k] = m_last[k] ? 2 : 0;
          end
          default: if (dig_ready[k]) begin
            m_phase[k] = 0; m_h[k] = IV_P;
          end
        endcase
      end
    end
  end

  // Per-cycle comparison of ready/valid/busy/digest against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        logic ev, er, eb;
        logic [127:0] ed, ad;
        er = (m_phase[k] == 0) && !rst;
        ev = (m_phase[k] == 2);
        eb = !((m_phase[k] == 0) && (m_idx[k] == 0));
        ed = ev ? digest_of(m_h[k]) : 128'd0;
        ad = ev ? dig[k] : 128'd0;
        check($sformatf("cycle_u%0d", 1 << k), {rdy[k], dvalid[k], busy[k], ad}, {er, ev, eb, ed});
      end
    end
  end

  // Called at a stable point after a rising edge; returns just after the transfer edge.
  task automatic send_word(input int k, input logic [31:0] d, input logic l);
    int guard = 0;
    in_data[k] = d; in_last[k] = l; in_valid[k] = 1'b1;
    while (!rdy[k] && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!rdy[k]) check("ready_timeout", {159'd0, rdy[k]}, 160'd1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0; in_last[k] = 1'b0;
  endtask

  task automatic send_block(input int k, input logic [511:0] blk, input logic [15:0] last_mask,
                            input int gap_max);
    for (int j = 0; j < 16; j++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      send_word(k, blk[32 * j +: 32], last_mask[j]);
    end
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dvalid[k] && lat < 300);
    if (!dvalid[k]) check("valid_timeout", {159'd0, dvalid[k]}, 160'd1);
  endtask

  task automatic wait_ready(input int k, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rdy[k] && lat < 300);
  endtask

  task automatic accept(input int k, input int hold, output logic [127:0] d);
    repeat (hold) @(negedge clk);
    d = dig[k];
    dig_ready[k] = 1'b1;
    @(posedge clk); #1;
    dig_ready[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int nb;
    logic [127:0] d;
    logic [511:0] blk;
    for (int k = 0; k < 3; k++) begin
      in_data[k] = '0; in_valid[k] = 1'b0; in_last[k] = 1'b0; dig_ready[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    check("reset_outputs_u1", {rdy[0], dvalid[0], busy[0], dig[0]}, 160'd0);
    check("reset_outputs_u4", {rdy[2], dvalid[2], busy[2], dig[2]}, 160'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model to published digests.
    check("model_empty", digest_of(md5_compress(IV_P, blk_empty())), D_EMPTY);
    check("model_abc", digest_of(md5_compress(IV_P, blk_abc())), D_ABC);
    check("model_num", digest_of(md5_compress(md5_compress(IV_P, blk_num(0)), blk_num(1))), D_NUM);

    // Empty message, UNROLL=1.
    send_block(0, blk_empty(), 16'h8000, 0);
    wait_valid(0, lat);
    check("lat_empty_u1", lat, 66);
    accept(0, 0, d);
    check("dig_empty_u1", d, D_EMPTY);

    // "abc" on every unroll factor.
    for (int k = 0; k < 3; k++) begin
      send_block(k, blk_abc(), 16'h8000, 0);
      wait_valid(k, lat);
      check($sformatf("lat_abc_u%0d", 1 << k), lat, 64 / (1 << k) + 2);
      accept(k, 0, d);
      check($sformatf("dig_abc_u%0d", 1 << k), d, D_ABC);
    end

    // Two-block message; input returns ready right after block-1 ADD.
    send_block(0, blk_num(0), 16'h0000, 0);
    wait_ready(0, lat);
    check("ready_return_u1", lat, 66);
    @(posedge clk); #1;
    send_block(0, blk_num(1), 16'h8000, 0);
    wait_valid(0, lat);
    accept(0, 0, d);
    check("dig_num_u1", d, D_NUM);

    // Input gaps, 20-cycle digest stall, then an immediate second message.
    send_block(0, blk_num(0), 16'h0000, 3);
    send_block(0, blk_num(1), 16'h8000, 3);
    wait_valid(0, lat);
    accept(0, 20, d);
    check("dig_num_stall", d, D_NUM);
    send_block(0, blk_empty(), 16'h8000, 0);
    wait_valid(0, lat);
    accept(0, 0, d);
    check("dig_empty_after_stall", d, D_EMPTY);

    // Reset in the middle of block 1 abandons the message.
    send_block(0, blk_num(0), 16'h0000, 0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (dvalid[0]) seen++;
    end
    check("no_digest_after_reset", seen, 0);
    @(posedge clk); #1;
    send_block(0, blk_abc(), 16'h8000, 0);
    wait_valid(0, lat);
    accept(0, 0, d);
    check("dig_abc_after_reset", d, D_ABC);

    // in_last on words 3 and 9 only: block stays non-final.
    send_block(0, blk_num(0), 16'h0208, 0);
    send_block(0, blk_num(1), 16'h8000, 0);
    wait_valid(0, lat);
    accept(0, 0, d);
    check("dig_num_last_noise", d, D_NUM);

    // Random multi-block messages, random gaps, random last noise and stalls.
    for (int r = 0; r < 9; r++) begin
      int k;
      k  = r % 3;
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        for (int j = 0; j < 16; j++) blk[32 * j +: 32] = $urandom();
        send_block(k, blk, {(b == nb - 1), 15'($urandom())}, 2);
      end
      wait_valid(k, lat);
      accept(k, $urandom_range(0, 5), d);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/md5_block_sequencer.md
Name: md5_block_sequencer

Overview:
- Iterative MD5 compression controller.
- Accepts pre-padded 512-bit message blocks as a stream of 32-bit words over a valid/ready handshake.
- Sequences the 64 MD5 steps over one shared step datapath (UNROLL steps per cycle) and chains the intermediate hash across blocks.
- Presents the final 128-bit digest on a valid/ready output; replaces the fully unrolled four-round structure when area matters.

Parameters:
- UNROLL, 1, MD5 steps evaluated per clock; legal values 1, 2, 4; RUN state lasts 64/UNROLL cycles.

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  reset; synchronous, active-high
- in_data_i  input  32  message word, MD5 little-endian word order (word j = bytes 4j..4j+3, byte 4j in bits [7:0])
- in_valid_i  input  1  in_data_i valid
- in_last_i  input  1  marks word 15 of the final block; sampled only with word 15
- in_ready_o  output  1  sequencer accepts a word this cycle
- digest_o  output  128  final digest; [127:120] = digest byte 0 (reads as the standard hex string)
- digest_valid_o  output  1  digest_o valid
- digest_ready_i  input  1  consumer accepts digest
- busy_o  output  1  high in any state except IDLE

Behaviour:
- Reset:
  - state=IDLE; chaining H = IV {67452301, EFCDAB89, 98BADCFE, 10325476}; word index=0; step counter=0.
  - in_ready_o=0, digest_valid_o=0, digest_o=0, busy_o=0.
  - Reset at any cycle, including mid-RUN or with a digest pending, abandons all work with no output; an un-accepted digest is discarded.
- States: IDLE, LOAD, RUN, ADD, DONE.
- IDLE: in_ready_o=1. A word transfer (in_valid_i & in_ready_o) writes M[0], sets index=1 and moves to LOAD.
- LOAD: in_ready_o=1. Each transfer writes M[index] and increments index. Gaps (valid low) are allowed and stall.
  - On the transfer of word 15: latch last = in_last_i, copy H into working a/b/c/d, step=0, go to RUN.
  - in_last_i on words 0..14 is ignored.
- RUN: in_ready_o=0. Each cycle applies UNROLL consecutive steps i = step..step+UNROLL-1:
  - F = (b&c)|(~b&d), i<16; (d&b)|(~d&c), i<32; b^c^d, i<48; c^(b|~d), otherwise.
  - g = i, (5i+1) mod 16, (3i+5) mod 16, (7i) mod 16 for the same four ranges.
  - Update: a'=d, d'=c, c'=b, b' = b + rotl(a+F+K[i]+M[g], S[i]); all adds mod 2^32, carries discarded.
  - step += UNROLL; after step 63 completes, go to ADD. RUN lasts exactly 64/UNROLL cycles.
- ADD (1 cycle): H += {a,b,c,d} per word mod 2^32.
  - If last=0: go to IDLE (index=0, H kept) for the next block.
  - If last=1: go to DONE; digest_o = byte-swapped concatenation of H0..H3; digest_valid_o=1.
- DONE: digest_o and digest_valid_o held stable until digest_ready_i=1.
  - On acceptance: digest_valid_o=0 the next cycle, H=IV, go to IDLE.
  - in_ready_o=0 throughout DONE.
- Latency: word 15 accepted at cycle t gives digest_valid_o at t+64/UNROLL+2.
- Word 0 of the next message can be accepted the cycle after digest acceptance; no bubble between blocks beyond ADD.
- No padding or length insertion is done in this block; the host supplies fully padded blocks.

Decomposition:
- md5_pkg holds:
  - K[0:63] constant table (RFC 1321 values, including K[39]=BEBFBC70);
  - shift table S[0:63];
  - IV constants;
  - state enum typedef;
  - functions f_round(i,b,c,d) and g_index(i).
- Sub-module md5_step: combinational single MD5 step with inputs a, b, c, d, m, k, s and round select, output {a',b',c',d'}.
  - Instantiate UNROLL copies in a chain.
  - The message word mux M[g] and K/S lookup stay in the sequencer.

Test Plan:
- MD5(""): one block, word0=00000080, words1..15=0, last=1, UNROLL=1 -> digest_o=d41d8cd98f00b204e9800998ecf8427e, valid exactly 66 cycles after word 15.
- MD5("abc"): word0=80636261, word14=00000018, others 0 -> 900150983cd24fb0d6963f7d28e17f72; repeat with UNROLL=2 and 4, latency 34 and 18.
- RFC 1321 80-char "1234567890"x8: two padded blocks, last only on block 2 -> 57edf4a22be3c955ac49da2e2107b67a. Check in_ready_o=0 during RUN and returns high after block-1 ADD.
- Backpressure: random in_valid_i gaps during LOAD; hold digest_ready_i=0 for 20 cycles in DONE. Expect the same digest, stable and valid throughout, with in_ready_o=0. Then hash "" back-to-back and expect d41d8cd9... (H reinitialised).
- Reset mid-operation: assert rst_i during RUN of block 1 of the two-block vector, then send "abc". Expect no digest from the aborted message, then 900150983cd24fb0d6963f7d28e17f72.
- in_last_i=1 asserted on words 3 and 9 but 0 on word 15 of block 1 -> treated as non-final; two-block vector still gives 57edf4a2....
